// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte-stream requesters.
// Optional build macro ARB_HDR_EN: prefix every grant with header byte 8'hA0 | owner.
module uart_tx_arb #(
  parameter int NREQ      = 4,
  parameter int MAX_BYTES = 0
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   vld_i,
  input  logic [NREQ-1:0]   last_i,
  input  logic [8*NREQ-1:0] data_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   ack_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_go_o,
  input  logic              tx_busy_i,
  output logic [1:0]        owner_o,
  output logic              active_o
);

  localparam int CW = (MAX_BYTES < 1) ? 1 : $clog2(MAX_BYTES + 1);

  typedef enum logic [1:0] {IDLE, GRANT, SETTLE, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_go_q, tx_go_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            active_q, active_d;
  logic            sent_last_q, sent_last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
`ifdef ARB_HDR_EN
  logic            hdr_pend_q, hdr_pend_d;
`endif

  logic            sel_req, sel_vld, sel_last;
  logic [7:0]      sel_data;
  logic [1:0]      pick;
  logic            pick_vld;
  logic            cap_hit;

  // Only the current owner's request lines matter while granted.
  always_comb begin
    sel_req  = 1'b0;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (owner_q == 2'(j)) begin
        sel_req  = req_i[j];
        sel_vld  = vld_i[j];
        sel_last = last_i[j];
        sel_data = data_i[8*j +: 8];
      end
    end
  end

  // First requester above the pointer, wrapping modulo NREQ.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!pick_vld && req_i[j] && (j == ((int'(ptr_q) + k) % NREQ))) begin
          pick     = 2'(j);
          pick_vld = 1'b1;
        end
      end
    end
  end

  assign cap_hit = (MAX_BYTES != 0) && (cnt_q == CW'(MAX_BYTES));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    tx_go_d     = 1'b0;
    tx_data_d   = tx_data_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    active_d    = active_q;
    sent_last_d = sent_last_q;
    cnt_d       = cnt_q;
`ifdef ARB_HDR_EN
    hdr_pend_d  = hdr_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          for (int j = 0; j < NREQ; j++) gnt_d[j] = (pick == 2'(j));
          owner_d  = pick;
          active_d = 1'b1;
          cnt_d    = '0;
`ifdef ARB_HDR_EN
          hdr_pend_d = 1'b1;
`endif
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (!sel_req) begin
          gnt_d    = '0;
          active_d = 1'b0;
          ptr_d    = owner_q;
          cnt_d    = '0;
          state_d  = IDLE;
        end
`ifdef ARB_HDR_EN
        else if (hdr_pend_q) begin
          if (!tx_busy_i) begin
            tx_data_d   = {6'b101000, owner_q};
            tx_go_d     = 1'b1;
            sent_last_d = 1'b0;
            hdr_pend_d  = 1'b0;
            state_d     = SETTLE;
          end
        end
`endif
        else if (sel_vld && !tx_busy_i) begin
          tx_data_d   = sel_data;
          tx_go_d     = 1'b1;
          ack_d       = gnt_q;
          sent_last_d = sel_last;
          cnt_d       = cnt_q + CW'(1);
          state_d     = SETTLE;
        end
      end
      // busy from the UART may not have risen yet; ignore it for one cycle
      SETTLE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          if (sent_last_q || cap_hit) begin
            gnt_d    = '0;
            active_d = 1'b0;
            ptr_d    = owner_q;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            state_d  = GRANT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      tx_data_q   <= '0;
      tx_go_q     <= 1'b0;
      owner_q     <= '0;
      ptr_q       <= 2'(NREQ - 1);
      active_q    <= 1'b0;
      sent_last_q <= 1'b0;
      cnt_q       <= '0;
`ifdef ARB_HDR_EN
      hdr_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      tx_data_q   <= tx_data_d;
      tx_go_q     <= tx_go_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      active_q    <= active_d;
      sent_last_q <= sent_last_d;
      cnt_q       <= cnt_d;
`ifdef ARB_HDR_EN
      hdr_pend_q  <= hdr_pend_d;
`endif
    end
  end

  assign gnt_o     = gnt_q;
  assign ack_o     = ack_q;
  assign tx_data_o = tx_data_q;
  assign tx_go_o   = tx_go_q;
  assign owner_o   = owner_q;
  assign active_o  = active_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: transaction-level model of packets, grants and
// round-robin order, checked every cycle, plus directed scenarios with literal results.
module tb_uart_tx_arb;
  localparam int N        = 4;
  localparam int CAP      = 4;
  localparam int BUSY_LEN = 10;

  typedef logic [7:0] u8;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [3:0] req = '0, vld = '0, last = '0;
  logic [31:0] data = '0;
  logic       tx_busy = 1'b0;
  logic [3:0] gnt_o, ack_o;
  logic [7:0] tx_data_o;
  logic       tx_go_o;
  logic [1:0] owner_o;
  logic       active_o;

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(N), .MAX_BYTES(CAP)) dut (
    .clk(clk), .nRst(nRst),
    .req_i(req), .vld_i(vld), .last_i(last), .data_i(data),
    .gnt_o(gnt_o), .ack_o(ack_o), .tx_data_o(tx_data_o), .tx_go_o(tx_go_o),
    .tx_busy_i(tx_busy), .owner_o(owner_o), .active_o(active_o)
  );

  int n_chk = 0, n_pass = 0;

  // requester side
  u8  pkt[4][$];
  int pos[4];
  bit want[4], wd_pend[4], vld_en[4];
  int vld_pct = 100;
  bit rand_mode = 0;

  // model of the arbiter's externally visible bookkeeping
  int  ptr = 3, cur = 0, gbytes = 0, since_go = 100, bcnt = 0;
  bit  prev_active = 0, lsent = 0, wdflag = 0, hdr_sent = 0, live_flagged = 0;
  u8   last_tx = '0;
  u8   txlog[$];
  int  ownlog[$], acklog[$];

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int rr(int p, logic [3:0] r);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit all_idle();
    return !(want[0] | want[1] | want[2] | want[3]) && !active_o && !tx_busy;
  endfunction

  task automatic start(int i);
    pos[i] = 0; want[i] = 1; wd_pend[i] = 0;
  endtask

  task automatic check_cycle();
    logic [3:0] exp_g;
    int w;
    since_go++;
    exp_g = active_o ? (4'b1 << owner_o) : 4'b0;
    chk("gnt_vs_owner", gnt_o, exp_g);
    if (!prev_active) begin
      chk("grant_on_req", active_o, |req);
      if (active_o) begin
        w = rr(ptr, req);
        chk("rr_owner", owner_o, w);
        cur = w; gbytes = 0; lsent = 0; wdflag = 0; hdr_sent = 0; live_flagged = 0;
        ownlog.push_back(w);
      end else chk("owner_hold_idle", owner_o, cur);
    end else begin
      if (!req[cur]) wdflag = 1;
      chk("owner_hold", owner_o, cur);
      if (!active_o) begin
        chk("release_reason", int'(lsent || wdflag || gbytes == CAP), 1);
        ptr = cur;
      end
    end
    if (tx_go_o) chk("go_while_busy", tx_busy, 0);
    if (ack_o != 0) begin
      chk("ack_onehot", ack_o, 4'b1 << cur);
      chk("ack_with_go", tx_go_o, 1);
      chk("ack_req_vld", {req[cur], vld[cur]}, 2'b11);
`ifdef ARB_HDR_EN
      chk("hdr_before_data", hdr_sent, 1);
`endif
      if (pos[cur] < pkt[cur].size()) chk("tx_data", tx_data_o, pkt[cur][pos[cur]]);
      else chk("ack_beyond_pkt", pos[cur], pkt[cur].size() - 1);
      gbytes++;
      chk("cap_respected", int'(gbytes <= CAP), 1);
      lsent = (pos[cur] == pkt[cur].size() - 1);
      pos[cur]++;
      acklog.push_back(cur);
      txlog.push_back(tx_data_o);
    end else if (tx_go_o) begin
`ifdef ARB_HDR_EN
      chk("hdr_byte", tx_data_o, 8'hA0 | cur);
      chk("hdr_once", {hdr_sent, gbytes == 0}, 2'b01);
      hdr_sent = 1;
      txlog.push_back(tx_data_o);
`else
      chk("go_without_ack", ack_o, 4'b1 << cur);
`endif
    end else chk("tx_data_hold", tx_data_o, last_tx);
    if (tx_go_o) since_go = 0;
    last_tx = tx_data_o;
    if (active_o && (lsent || gbytes == CAP) && since_go > BUSY_LEN + 5 && !live_flagged) begin
      chk("release_late", active_o, 0);
      live_flagged = 1;
    end
    prev_active = active_o;
  endtask

  task automatic uart_tick();
    if (tx_go_o) begin tx_busy = 1; bcnt = BUSY_LEN; end
    else if (bcnt > 0) begin bcnt--; if (bcnt == 0) tx_busy = 0; end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (wd_pend[i]) begin
        req[i] = 0; vld[i] = 1; last[i] = 0;
        data[8*i +: 8] = (pos[i] < pkt[i].size()) ? pkt[i][pos[i]] : 8'h00;
        wd_pend[i] = 0; want[i] = 0;
      end else begin
        if (want[i] && pos[i] >= pkt[i].size()) want[i] = 0;
        req[i] = want[i];
        if (want[i]) begin
          data[8*i +: 8] = pkt[i][pos[i]];
          last[i] = (pos[i] == pkt[i].size() - 1);
          vld[i] = vld_en[i] && ($urandom_range(99) < vld_pct);
        end else begin
          vld[i] = 0; last[i] = 0; data[8*i +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    uart_tick();
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!want[i] && !wd_pend[i] && $urandom_range(99) < 3) begin
          pkt[i].delete();
          for (int b = 0; b < $urandom_range(7, 1); b++) pkt[i].push_back(8'($urandom));
          start(i);
        end else if (want[i] && pos[i] < pkt[i].size() && $urandom_range(999) < 5)
          wd_pend[i] = 1;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    #2 nRst = 0;
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_tx_go", tx_go_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_active", active_o, 0);
    for (int i = 0; i < N; i++) begin want[i] = 0; wd_pend[i] = 0; vld_en[i] = 1; end
    req = '0; vld = '0; last = '0;
    ptr = 3; cur = 0; prev_active = 0; last_tx = '0; since_go = 100;
    txlog.delete(); ownlog.delete(); acklog.delete();
    repeat (2) begin @(negedge clk); uart_tick(); end
    nRst = 1;
  endtask

  task automatic run_idle(int maxc, string name);
    int c = 0;
    do begin step(); c++; end while (!all_idle() && c < maxc);
    chk({name, "_timeout"}, all_idle(), 1);
  endtask

  initial begin
    u8  exp_tx[$];
    int exp_own[$], exp_ack[$];
    int c;

    // single requester, three bytes
    do_reset();
    vld_pct = 100;
    pkt[0] = '{8'h11, 8'h22, 8'h33};
    start(0);
    run_idle(300, "single");
`ifdef ARB_HDR_EN
    exp_tx = '{8'hA0, 8'h11, 8'h22, 8'h33};
`else
    exp_tx = '{8'h11, 8'h22, 8'h33};
`endif
    chk("single_ntx", txlog.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < txlog.size(); i++) chk("single_byte", txlog[i], exp_tx[i]);
    chk("single_acks", acklog.size(), 3);
    chk("single_gnt_end", gnt_o, 0);
    chk("single_active_end", active_o, 0);

    // simultaneous req0/req2, twice
    do_reset();
    pkt[0] = '{8'h01, 8'h02};
    pkt[2] = '{8'h03, 8'h04};
    start(0); start(2);
    run_idle(400, "rr1");
    start(0); start(2);
    run_idle(400, "rr2");
    exp_own = '{0, 2, 0, 2};
    chk("rr_ngrants", ownlog.size(), 4);
    for (int i = 0; i < 4 && i < ownlog.size(); i++) chk("rr_order", ownlog[i], exp_own[i]);

    // byte cap: req1 six bytes, req3 pending
    do_reset();
    pkt[1] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    pkt[3] = '{8'h20, 8'h21, 8'h22};
    start(1); start(3);
    run_idle(1000, "cap");
    exp_ack = '{1, 1, 1, 1, 3, 3, 3, 1, 1};
    exp_own = '{1, 3, 1};
    chk("cap_nacks", acklog.size(), 9);
    for (int i = 0; i < 9 && i < acklog.size(); i++) chk("cap_ack_order", acklog[i], exp_ack[i]);
    chk("cap_ngrants", ownlog.size(), 3);
    for (int i = 0; i < 3 && i < ownlog.size(); i++) chk("cap_grant_order", ownlog[i], exp_own[i]);

    // withdrawal in GRANT with same-cycle vld
    do_reset();
    pkt[1] = '{8'h30, 8'h31};
    pkt[3] = '{8'h40};
    vld_en[1] = 0;
    start(1); start(3);
    c = 0;
    begin
      int held = 0;
      while (held < 2 && c < 200) begin
        step(); c++;
        if (gnt_o[1] && !tx_busy && since_go > 3) held++; else held = 0;
      end
    end
    chk("wd_wait_timeout", int'(c < 200), 1);
    wd_pend[1] = 1;
    step();
    step();
    chk("wd_no_go", tx_go_o, 0);
    chk("wd_no_ack", ack_o, 0);
    chk("wd_gnt_drop", gnt_o, 0);
    step();
    chk("wd_next_active", active_o, 1);
    chk("wd_next_owner", owner_o, 3);
    vld_en[1] = 1;
    run_idle(300, "wd");

    // reset while a frame is in flight
    pkt[0] = '{8'h50, 8'h51, 8'h52};
    start(0);
    c = 0;
    do begin step(); c++; end while (!tx_go_o && c < 300);
    chk("midframe_go_seen", tx_go_o, 1);
    repeat (3) step();
    do_reset();
    pkt[2] = '{8'h60};
    start(2);
    run_idle(300, "post_reset");
    chk("post_reset_nacks", acklog.size(), 1);
    if (txlog.size() > 0) chk("post_reset_byte", txlog[txlog.size() - 1], 8'h60);
    else chk("post_reset_ntx", txlog.size(), 1);

    // requester 2, two bytes (header case when enabled)
    do_reset();
    pkt[2] = '{8'h55, 8'h66};
    start(2);
    run_idle(300, "hdr");
`ifdef ARB_HDR_EN
    exp_tx = '{8'hA2, 8'h55, 8'h66};
`else
    exp_tx = '{8'h55, 8'h66};
`endif
    chk("hdr_ntx", txlog.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < txlog.size(); i++) chk("hdr_seq", txlog[i], exp_tx[i]);
    chk("hdr_nacks", acklog.size(), 2);

    // randomized traffic with withdrawals
    do_reset();
    vld_pct = 70;
    rand_mode = 1;
    repeat (4000) step();
    rand_mode = 0;
    run_idle(3000, "drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
